// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and CRC-8 helpers for the configuration-chain loader.
package ccff_chain_loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      VERIFY = 3'd2,
      DONE   = 3'd3,
      ERROR  = 3'd4
   } state_t;

   localparam logic [7:0] CRC8_POLY = 8'h07;
   localparam logic [7:0] CRC8_INIT = 8'h00;

   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
      logic fb;
      fb = crc[7] ^ bit_in;
      return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/ccff_crc8_serial.sv
// Bit-serial CRC-8 accumulator; one bit folded in per enabled cycle.
module ccff_crc8_serial
   import ccff_chain_loader_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [7:0] crc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= CRC8_INIT;
      end else if (clr) begin
         crc <= CRC8_INIT;
      end else if (en) begin
         crc <= crc8_step(crc, bit_in);
      end
   end

endmodule

// File: rtl/ccff_chain_loader.sv
// Writer-end loader for the tile configuration chain: serialises stream words
// onto ccff_head, then recirculates the chain once to CRC-check the readback.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, waiting for start
// LOAD   | accepting words, shifting buffer MSB into the chain
// VERIFY | chain looped tail->head for CHAIN_LEN cycles, CRC of readback
// DONE   | readback CRC matched, cfg_done held
// ERROR  | readback CRC mismatched, cfg_error held
module ccff_chain_loader
   import ccff_chain_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 8,
   parameter int WORD_W    = 8,
   localparam int CNT_W    = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              start,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              chain_clk_en,
   output logic              busy,
   output logic              cfg_done,
   output logic              cfg_error,
   output logic [CNT_W-1:0]  bit_count
);

   localparam int BUF_CNT_W = $clog2(WORD_W + 1);
   localparam int ACC_W     = $clog2(CHAIN_LEN + WORD_W + 1);

   state_t               state_q, state_d;
   logic [WORD_W-1:0]    buf_data_q, buf_data_d;
   logic [BUF_CNT_W-1:0] buf_cnt_q, buf_cnt_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0]     bit_count_d;
   logic                 cfg_done_d, cfg_error_d;

   logic                 buf_empty, load_en, handshake, last_shift;
   logic [ACC_W-1:0]     rem_bits;
   logic [BUF_CNT_W-1:0] take_cnt;
   logic                 crc_clr, crc_in_en, crc_out_en;
   logic [7:0]           crc_in, crc_out;

   assign buf_empty  = (buf_cnt_q == '0);
   assign load_en    = (state_q == LOAD) && !buf_empty;
   assign last_shift = (bit_count == CNT_W'(CHAIN_LEN - 1));

   // acc_q counts bits taken into the buffer, so the final word is trimmed
   // to exactly what the chain still needs and its spare LSBs are dropped.
   assign rem_bits = ACC_W'(CHAIN_LEN) - acc_q;
   assign take_cnt = (rem_bits >= ACC_W'(WORD_W)) ? BUF_CNT_W'(WORD_W) : BUF_CNT_W'(rem_bits);

   assign s_ready = (state_q == LOAD) && (acc_q < ACC_W'(CHAIN_LEN)) &&
                    (buf_empty || (buf_cnt_q == BUF_CNT_W'(1)));
   assign handshake    = s_valid && s_ready;
   assign chain_clk_en = load_en || (state_q == VERIFY);
   assign ccff_head    = (state_q == VERIFY) ? ccff_tail :
                         (load_en ? buf_data_q[WORD_W-1] : 1'b0);

   always_comb begin
      state_d     = state_q;
      buf_data_d  = buf_data_q;
      buf_cnt_d   = buf_cnt_q;
      acc_d       = acc_q;
      bit_count_d = bit_count;
      cfg_done_d  = cfg_done;
      cfg_error_d = cfg_error;
      crc_clr     = 1'b0;
      crc_in_en   = 1'b0;
      crc_out_en  = 1'b0;

      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_d     = LOAD;
               buf_data_d  = '0;
               buf_cnt_d   = '0;
               acc_d       = '0;
               bit_count_d = '0;
               cfg_done_d  = 1'b0;
               cfg_error_d = 1'b0;
               crc_clr     = 1'b1;
            end
         end
         LOAD: begin
            if (load_en) begin
               buf_data_d = buf_data_q << 1;
               buf_cnt_d  = buf_cnt_q - BUF_CNT_W'(1);
               crc_in_en  = 1'b1;
               if (last_shift) begin
                  state_d     = VERIFY;
                  bit_count_d = '0;
               end else begin
                  bit_count_d = bit_count + CNT_W'(1);
               end
            end
            // a word arriving on the last buffered bit replaces the shifted remnant
            if (handshake) begin
               buf_data_d = s_data;
               buf_cnt_d  = take_cnt;
               acc_d      = acc_q + ACC_W'(WORD_W);
            end
         end
         VERIFY: begin
            crc_out_en = 1'b1;
            if (last_shift) begin
               bit_count_d = '0;
               if (crc8_step(crc_out, ccff_tail) == crc_in) begin
                  state_d    = DONE;
                  cfg_done_d = 1'b1;
               end else begin
                  state_d     = ERROR;
                  cfg_error_d = 1'b1;
               end
            end else begin
               bit_count_d = bit_count + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state_q    <= IDLE;
         buf_data_q <= '0;
         buf_cnt_q  <= '0;
         acc_q      <= '0;
         bit_count  <= '0;
         cfg_done   <= 1'b0;
         cfg_error  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_data_q <= buf_data_d;
         buf_cnt_q  <= buf_cnt_d;
         acc_q      <= acc_d;
         bit_count  <= bit_count_d;
         cfg_done   <= cfg_done_d;
         cfg_error  <= cfg_error_d;
         busy       <= (state_d == LOAD) || (state_d == VERIFY);
      end
   end

   ccff_crc8_serial u_crc_in (
      .clk    (prog_clk),
      .rst_n  (prog_reset_n),
      .clr    (crc_clr),
      .en     (crc_in_en),
      .bit_in (ccff_head),
      .crc    (crc_in)
   );

   ccff_crc8_serial u_crc_out (
      .clk    (prog_clk),
      .rst_n  (prog_reset_n),
      .clr    (crc_clr),
      .en     (crc_out_en),
      .bit_in (ccff_tail),
      .crc    (crc_out)
   );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: three chain lengths, each with a shift-register
// model of the tile chain; expected head bits and completion flags are queued.
module tb_ccff_chain_loader;

   typedef struct packed {
      logic is_flag;
      logic b;
      logic done;
      logic err;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] s_data;
   logic       s_valid;
   int         sel = 0;

   logic       start_a, start_b, start_c, sv_a, sv_b, sv_c;
   logic       rdy_a, rdy_b, rdy_c, head_a, head_b, head_c, tail_a, tail_b, tail_c;
   logic       en_a, en_b, en_c, busy_a, busy_b, busy_c;
   logic       done_a, done_b, done_c, err_a, err_b, err_c;
   logic [3:0] bc_a;
   logic [4:0] bc_b, bc_c;

   logic [7:0]  chain_a;
   logic [19:0] chain_b;
   logic [15:0] chain_c;

   logic       rdy_sel, head_sel, en_sel, busy_sel, done_sel, err_sel;
   logic [4:0] bc_sel;

   int   en_total   = 0;
   int   cyc        = 0;
   int   corrupt_at = -1;
   int   n_vec      = 0;
   int   n_fail     = 0;
   exp_t exp_q[$];

   assign start_a = start & (sel == 0);
   assign start_b = start & (sel == 1);
   assign start_c = start & (sel == 2);
   assign sv_a    = s_valid & (sel == 0);
   assign sv_b    = s_valid & (sel == 1);
   assign sv_c    = s_valid & (sel == 2);

   assign rdy_sel  = (sel == 0) ? rdy_a  : (sel == 1) ? rdy_b  : rdy_c;
   assign head_sel = (sel == 0) ? head_a : (sel == 1) ? head_b : head_c;
   assign en_sel   = (sel == 0) ? en_a   : (sel == 1) ? en_b   : en_c;
   assign busy_sel = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
   assign done_sel = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
   assign err_sel  = (sel == 0) ? err_a  : (sel == 1) ? err_b  : err_c;
   assign bc_sel   = (sel == 0) ? {1'b0, bc_a} : (sel == 1) ? bc_b : bc_c;

   ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_dut_a (
      .prog_clk(clk), .prog_reset_n(rst_n), .start(start_a), .s_data(s_data),
      .s_valid(sv_a), .s_ready(rdy_a), .ccff_head(head_a), .ccff_tail(tail_a),
      .chain_clk_en(en_a), .busy(busy_a), .cfg_done(done_a), .cfg_error(err_a),
      .bit_count(bc_a)
   );

   ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut_b (
      .prog_clk(clk), .prog_reset_n(rst_n), .start(start_b), .s_data(s_data),
      .s_valid(sv_b), .s_ready(rdy_b), .ccff_head(head_b), .ccff_tail(tail_b),
      .chain_clk_en(en_b), .busy(busy_b), .cfg_done(done_b), .cfg_error(err_b),
      .bit_count(bc_b)
   );

   ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_dut_c (
      .prog_clk(clk), .prog_reset_n(rst_n), .start(start_c), .s_data(s_data),
      .s_valid(sv_c), .s_ready(rdy_c), .ccff_head(head_c), .ccff_tail(tail_c),
      .chain_clk_en(en_c), .busy(busy_c), .cfg_done(done_c), .cfg_error(err_c),
      .bit_count(bc_c)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // chain models: last flop drives ccff_tail; optional single-bit upset on chain A
   assign tail_a = chain_a[7];
   assign tail_b = chain_b[19];
   assign tail_c = chain_c[15];

   always @(posedge clk) begin
      if (en_a) begin
         if (sel == 0 && en_total == corrupt_at)
            chain_a <= {chain_a[6:0], head_a} ^ 8'h08;
         else
            chain_a <= {chain_a[6:0], head_a};
      end
      if (en_b) chain_b <= {chain_b[18:0], head_b};
      if (en_c) chain_c <= {chain_c[14:0], head_c};
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (en_sel) en_total <= en_total + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name);
      n_vec++;
      n_fail++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   task automatic push_bits(input logic [31:0] val, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) exp_q.push_back('{1'b0, val[i], 1'b0, 1'b0});
   endtask

   task automatic push_flag(input logic done, input logic err);
      exp_q.push_back('{1'b1, 1'b0, done, err});
   endtask

   task automatic do_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (!busy_sel) begin
            @(negedge clk); #1;
            return;
         end
      end
      note_fail(tag);
   endtask

   task automatic wait_hs(input string tag, output int hs_cyc, output logic en_at);
      logic hs;
      hs_cyc = 0;
      en_at  = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         hs    = rdy_sel && s_valid;
         en_at = en_sel;
         @(posedge clk);
         hs_cyc = cyc;
         #1;
         if (hs) return;
      end
      note_fail(tag);
   endtask

   task automatic gap_check();
      int i;
      for (i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!en_sel) break;
      end
      if (i == 40) note_fail("gap_wait");
      repeat (2) begin
         @(negedge clk);
         check("gap_en", en_sel, 1'b0);
      end
      @(posedge clk); #1;
   endtask

   // monitor: pops one expectation per enabled chain edge and per busy fall
   initial begin
      logic busy_prev;
      exp_t e;
      busy_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_prev = 1'b0;
         end else begin
            if (en_sel) begin
               if (exp_q.size() == 0) note_fail("head_unexpected");
               else begin
                  e = exp_q.pop_front();
                  if (e.is_flag) note_fail("head_before_flags");
                  else check("head_bit", head_sel, e.b);
               end
            end
            if (busy_prev && !busy_sel) begin
               if (exp_q.size() == 0) note_fail("flags_unexpected");
               else begin
                  e = exp_q.pop_front();
                  if (!e.is_flag) note_fail("flags_early");
                  else check("done_err", {done_sel, err_sel}, {e.done, e.err});
               end
            end
            busy_prev = busy_sel;
         end
      end
   end

   initial begin
      int   base, c1, c2, i;
      logic e1, e2;

      rst_n = 1'b0; start = 1'b0; s_data = 8'h00; s_valid = 1'b0;
      #2;
      for (int k = 0; k < 3; k++) begin
         sel = k;
         #1;
         check("reset_ctrl", {rdy_sel, head_sel, en_sel, busy_sel, done_sel, err_sel}, 6'b0);
         check("reset_bit_count", bc_sel, 5'd0);
      end
      sel = 0;
      @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;

      // A5 load and clean readback
      push_bits(8'hA5, 8); push_bits(8'hA5, 8); push_flag(1'b1, 1'b0);
      s_data = 8'hA5; s_valid = 1'b1;
      base = en_total;
      do_start();
      wait_idle("a5_idle");
      s_valid = 1'b0;
      check("a5_done", {done_sel, err_sel, busy_sel}, 3'b100);
      check("a5_chain", chain_a, 8'hA5);
      check("a5_edges", en_total - base, 16);

      // same load with chain bit 3 upset after the last load shift
      push_bits(8'hA5, 8); push_bits(8'hAD, 8); push_flag(1'b0, 1'b1);
      corrupt_at = en_total + 7;
      s_valid = 1'b1;
      do_start();
      wait_idle("flip_idle");
      s_valid = 1'b0;
      corrupt_at = -1;
      check("flip_flags", {done_sel, err_sel, busy_sel}, 3'b010);

      // 20-bit chain, words with stalls between them
      sel = 1;
      push_bits(20'hFF00F, 20); push_bits(20'hFF00F, 20); push_flag(1'b1, 1'b0);
      base = en_total;
      do_start();
      s_data = 8'hFF; s_valid = 1'b1;
      wait_hs("hs_ff", c1, e1);
      s_valid = 1'b0;
      gap_check();
      s_data = 8'h00; s_valid = 1'b1;
      wait_hs("hs_00", c1, e1);
      s_valid = 1'b0;
      gap_check();
      s_data = 8'hF3; s_valid = 1'b1;
      wait_hs("hs_f3", c1, e1);
      s_valid = 1'b0;
      check("ready_after_final", rdy_sel, 1'b0);
      wait_idle("b_idle");
      check("b_done", {done_sel, err_sel}, 2'b10);
      check("b_edges", en_total - base, 40);
      check("b_chain", chain_b, 20'hFF00F);

      // 16-bit chain, back-to-back words
      sel = 2;
      push_bits(16'h817E, 16); push_bits(16'h817E, 16); push_flag(1'b1, 1'b0);
      s_data = 8'h81; s_valid = 1'b1;
      do_start();
      wait_hs("hs_81", c1, e1);
      check("hs1_en", e1, 1'b0);
      s_data = 8'h7E;
      wait_hs("hs_7e", c2, e2);
      check("hs2_on_last_bit", e2, 1'b1);
      check("hs_spacing", c2 - c1, 8);
      check("c_ready_after_final", rdy_sel, 1'b0);
      s_valid = 1'b0;
      wait_idle("c_idle");
      check("c_done", {done_sel, err_sel}, 2'b10);
      check("c_chain", chain_c, 16'h817E);

      // reset while loading at bit_count 5
      sel = 0;
      push_bits(8'hA5 >> 2, 6);
      s_data = 8'hA5; s_valid = 1'b1;
      do_start();
      for (i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bc_sel == 5'd5) break;
      end
      if (i == 40) note_fail("bc5_wait");
      #2 rst_n = 1'b0;
      #1;
      check("abort_ctrl", {rdy_sel, head_sel, en_sel, busy_sel, done_sel, err_sel}, 6'b0);
      check("abort_bit_count", bc_sel, 5'd0);
      s_valid = 1'b0;
      @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
      check("abort_queue", exp_q.size(), 0);
      push_bits(8'hA5, 8); push_bits(8'hA5, 8); push_flag(1'b1, 1'b0);
      s_valid = 1'b1;
      do_start();
      wait_idle("reload_idle");
      s_valid = 1'b0;
      check("reload_done", {done_sel, err_sel}, 2'b10);

      // start during VERIFY is ignored; start in DONE restarts
      push_bits(8'hA5, 8); push_bits(8'hA5, 8); push_flag(1'b1, 1'b0);
      push_bits(8'hA5, 8); push_bits(8'hA5, 8); push_flag(1'b1, 1'b0);
      s_valid = 1'b1;
      base = en_total;
      do_start();
      for (i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (en_total - base >= 10) break;
      end
      if (i == 60) note_fail("verify_wait");
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("start_in_verify_busy", busy_sel, 1'b1);
      wait_idle("ign_idle");
      check("ign_done", {done_sel, err_sel}, 2'b10);
      check("ign_edges", en_total - base, 16);
      do_start();
      check("restart_flags", {done_sel, busy_sel}, 2'b01);
      wait_idle("restart_idle");
      s_valid = 1'b0;
      check("restart_done", {done_sel, err_sel}, 2'b10);

      repeat (2) @(posedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Drives the configuration-chain protocol from the writer end: accepts bitstream words on a valid/ready stream and serialises them MSB-first onto `ccff_head` of a tile chain.
- Gates the chain clock via `chain_clk_en`, one chain shift per enabled `prog_clk` edge.
- After loading, recirculates the chain (`ccff_tail` -> `ccff_head`) for a non-destructive CRC readback check, then raises `cfg_done` or `cfg_error`.
- Sits at fabric top, between the bitstream source and the first tile's `ccff_head` / last tile's `ccff_tail`.

Parameters:
- CHAIN_LEN, 8, total configuration bits in the chain (>=1).
- WORD_W, 8, stream word width (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), bit-counter width (derived, not overridden).

Ports:
- prog_clk  input  1  single clock for loader and chain.
- prog_reset_n  input  1  asynchronous, active-low reset.
- start  input  1  pulse; begins a load from IDLE/DONE/ERROR.
- s_data  input  WORD_W  bitstream word, MSB shifted first.
- s_valid  input  1  s_data valid.
- s_ready  output  1  word accepted when s_valid && s_ready.
- ccff_head  output  1  serial data into chain.
- ccff_tail  input  1  serial data out of chain.
- chain_clk_en  output  1  enable to the top-level clock gate on the chain's prog_clk.
- busy  output  1  high in LOAD or VERIFY.
- cfg_done  output  1  chain loaded and verified.
- cfg_error  output  1  readback CRC mismatch.
- bit_count  output  CNT_W  bits shifted in current phase.

Behaviour:
- Clocking/reset:
  - One clock, `prog_clk`; `prog_reset_n` is asynchronous, active-low.
  - During reset all state clears: state=IDLE, s_ready=0, ccff_head=0, chain_clk_en=0, busy=0, cfg_done=0, cfg_error=0, bit_count=0, CRCs=0x00.
  - Reset mid-operation aborts; chain contents are undefined afterwards; a fresh start is required.
- States: IDLE, LOAD, VERIFY, DONE, ERROR.
- IDLE/DONE/ERROR:
  - start=1 -> LOAD next cycle; clears bit_count, both CRCs, cfg_done, cfg_error, word buffer.
  - start is ignored in LOAD and VERIFY.
- LOAD:
  - Internal word buffer holds the current word and its remaining-bit count.
  - s_ready=1 when the buffer is empty, or holds its last bit while chain_clk_en=1 (no bubble between back-to-back words).
  - chain_clk_en=1 iff the buffer is non-empty; ccff_head = buffer MSB (0 when empty).
  - Each enabled cycle: shift buffer left by 1, bit_count+1, crc_in updated with the bit.
  - Stalls (s_valid=0) hold the chain: chain_clk_en=0.
  - Transition: bit_count reaches CHAIN_LEN -> VERIFY next cycle, bit_count cleared.
  - If CHAIN_LEN is not a multiple of WORD_W, unused LSBs of the final word are discarded.
  - s_ready=0 once the final needed word is accepted.
- VERIFY:
  - chain_clk_en=1 every cycle; ccff_head = ccff_tail (combinational loop-back through the loader).
  - Each cycle crc_out is updated with ccff_tail; bit_count+1.
  - After CHAIN_LEN cycles the chain holds its loaded image again.
  - Then compare: crc_in==crc_out -> DONE (cfg_done=1), else ERROR (cfg_error=1).
  - Both flags are registered, sticky until start or reset, and mutually exclusive.
- Chain timing:
  - Chain flops and loader sample on the same enabled edge.
  - The first bit loaded appears on ccff_tail during the first VERIFY cycle.
  - Readback order equals load order.
- CRC:
  - CRC-8, polynomial 0x07, init 0x00, bit-serial.
  - fb = crc[7]^bit; crc <= {crc[6:0],0} ^ (fb ? 0x07 : 0x00).
- Latency: load of N=CHAIN_LEN bits with no stalls = N enabled cycles; verify = N cycles; plus one cycle per state transition.
- busy = (state==LOAD || state==VERIFY).
- All outputs are registered except s_ready, ccff_head and chain_clk_en, which are decoded from registered state only.
- The ccff_tail -> ccff_head path is the only comb input-to-output path.

Decomposition:
- Package ccff_chain_loader_pkg:
  - state enum (IDLE, LOAD, VERIFY, DONE, ERROR).
  - CRC8_POLY=8'h07, CRC8_INIT=8'h00.
- Sub-module ccff_crc8_serial:
  - ports: clk, rst_n, clr, en, bit_in, crc[7:0].
  - instantiated twice, once for crc_in and once for crc_out.

Test Plan:
- CHAIN_LEN=8, WORD_W=8, start, s_data=0xA5 with s_valid held -> ccff_head sequence 1,0,1,0,0,1,0,1 over 8 enabled cycles; then 8 VERIFY cycles; cfg_done=1, cfg_error=0; chain model holds 0xA5.
- Same load, bench model flips chain bit 3 before VERIFY -> cfg_error=1, cfg_done=0, busy=0.
- CHAIN_LEN=20, WORD_W=8, words 0xFF,0x00,0xF3, with s_valid dropped for 3 cycles between words -> chain_clk_en=0 during the gaps; exactly 20 enabled LOAD cycles; LSB nibble of 0xF3 never shifted; cfg_done=1.
- Back-to-back words 0x81,0x7E with s_valid continuous (CHAIN_LEN=16) -> s_ready pulses on the 8th bit of the first word, no idle cycle; head stream 1000000101111110.
- Assert prog_reset_n=0 mid-LOAD (bit_count=5) -> all outputs 0 immediately; after release, start reloads cleanly to cfg_done.
- start pulsed during VERIFY -> ignored, completion unchanged; start in DONE -> cfg_done clears next cycle, busy=1.
